// File: rtl/seg_scan_595.sv
// seg_scan_595: multiplexed 8-digit seven-segment driver behind a 16-bit 74HC595 chain.
//
// Each digit period is LOAD -> SHIFT -> LATCH -> HOLD. LOAD snapshots the current digit's
// code, enable and dot bit into a 16-bit frame {seg[7:0], sel[7:0]}. SHIFT clocks the frame
// out MSB first on ser/sclk. LATCH pulses rclk so the 595 outputs update. HOLD keeps the
// digit lit for DIGIT_HOLD cycles before the next digit index loads.
//
// All outputs are registered from the state and counters, so they trail the FSM state by
// one clk cycle. ser and sclk come from the same flop stage, so ser only ever changes on
// an edge where sclk is, or becomes, low.
//
// Parameters:
//   SCLK_HALF      clk cycles per sclk half period; also the rclk pulse width (1..255)
//   DIGIT_HOLD     clk cycles each digit stays latched (1..2^20-1)
//   SEG_ACTIVE_LOW 1: invert the segment byte in the frame
//   SEL_ACTIVE_LOW 1: selected digit driven 0, all others 1
//
// Ports:
//   clk          only clock, rising edge
//   rst          synchronous active-high reset
//   seg_data     digit i code at [5i+4:5i]
//   seg_data_en  bit i enables digit i
//   seg_dot_en   bit i lights the dp segment of digit i
//   ser          serial data to the 595 chain
//   sclk         595 shift clock
//   rclk         595 storage latch
//   frame_done   one-cycle pulse as the digit 7 rclk pulse ends

module seg_scan_595 #(
  parameter int unsigned SCLK_HALF      = 2,
  parameter int unsigned DIGIT_HOLD     = 12000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] seg_data,
  input  logic [7:0]  seg_data_en,
  input  logic [7:0]  seg_dot_en,
  output logic        ser,
  output logic        sclk,
  output logic        rclk,
  output logic        frame_done
);

  localparam logic [1:0] StLoad  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StLatch = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  // phase counter spans one full sclk period during SHIFT and one half period in LATCH
  localparam logic [8:0]  PhaseLast = 9'(2 * SCLK_HALF - 1);
  localparam logic [8:0]  HalfCnt   = 9'(SCLK_HALF);
  localparam logic [8:0]  HalfLast  = 9'(SCLK_HALF - 1);
  localparam logic [19:0] HoldLast  = 20'(DIGIT_HOLD - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  digit_q, digit_d;
  logic [8:0]  phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [19:0] hold_q, hold_d;
  logic [15:0] frame_q, frame_d;
  logic        ser_q, ser_d;
  logic        sclk_q, sclk_d;
  logic        rclk_q, rclk_d;
  logic        done_q, done_d;

  logic [4:0]  cur_code;
  logic        cur_en;
  logic        cur_dot;
  logic [7:0]  dec_seg;
  logic [7:0]  seg_raw;
  logic [7:0]  sel_raw;
  logic [7:0]  seg_byte;
  logic [7:0]  sel_byte;
  logic [15:0] load_frame;

  // Fields of the digit currently addressed; only consumed in LOAD.
  always_comb begin
    cur_code = seg_data[5 * 32'(digit_q) +: 5];
    cur_en   = seg_data_en[digit_q];
    cur_dot  = seg_dot_en[digit_q];
  end

  // Active-high {dp,g,f,e,d,c,b,a}. Codes 10/11 form the two halves of a '+' across
  // two adjacent digits.
  always_comb begin
    dec_seg = 8'h00;
    case (cur_code)
      5'd0:    dec_seg = 8'h3F;
      5'd1:    dec_seg = 8'h06;
      5'd2:    dec_seg = 8'h5B;
      5'd3:    dec_seg = 8'h4F;
      5'd4:    dec_seg = 8'h66;
      5'd5:    dec_seg = 8'h6D;
      5'd6:    dec_seg = 8'h7D;
      5'd7:    dec_seg = 8'h07;
      5'd8:    dec_seg = 8'h7F;
      5'd9:    dec_seg = 8'h6F;
      5'd10:   dec_seg = 8'h70;
      5'd11:   dec_seg = 8'h46;
      5'd12:   dec_seg = 8'h40;
      5'd13:   dec_seg = 8'h63;
      5'd14:   dec_seg = 8'h52;
      5'd15:   dec_seg = 8'h79;
      5'd16:   dec_seg = 8'h00;
      5'd17:   dec_seg = 8'h50;
      5'd18:   dec_seg = 8'h48;
      default: dec_seg = 8'h00;
    endcase
  end

  // A disabled digit drives no segments and selects nothing; polarity is applied last so
  // a disabled digit still turns every output off in either polarity.
  always_comb begin
    if (cur_en) begin
      seg_raw = dec_seg | {cur_dot, 7'b000_0000};
      sel_raw = 8'h01 << digit_q;
    end else begin
      seg_raw = 8'h00;
      sel_raw = 8'h00;
    end
    seg_byte   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    sel_byte   = SEL_ACTIVE_LOW ? ~sel_raw : sel_raw;
    load_frame = {seg_byte, sel_byte};
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    ser_d   = 1'b0;
    sclk_d  = 1'b0;
    rclk_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      StLoad: begin
        frame_d = load_frame;
        phase_d = 9'd0;
        bit_d   = 4'd15;
        state_d = StShift;
      end

      StShift: begin
        // first half of each bit period: sclk low, second half: sclk high
        ser_d  = frame_q[bit_q];
        sclk_d = (phase_q >= HalfCnt);
        if (phase_q == PhaseLast) begin
          phase_d = 9'd0;
          if (bit_q == 4'd0) begin
            state_d = StLatch;
          end else begin
            bit_d = bit_q - 4'd1;
          end
        end else begin
          phase_d = phase_q + 9'd1;
        end
      end

      StLatch: begin
        // ser keeps the last bit so it does not move while rclk is high
        ser_d  = frame_q[0];
        rclk_d = 1'b1;
        if (phase_q == HalfLast) begin
          phase_d = 9'd0;
          hold_d  = 20'd0;
          state_d = StHold;
        end else begin
          phase_d = phase_q + 9'd1;
        end
      end

      StHold: begin
        done_d = (hold_q == 20'd0) && (digit_q == 3'd7);
        if (hold_q == HoldLast) begin
          hold_d  = 20'd0;
          digit_d = digit_q + 3'd1;
          state_d = StLoad;
        end else begin
          hold_d = hold_q + 20'd1;
        end
      end

      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      digit_q <= 3'd0;
      phase_q <= 9'd0;
      bit_q   <= 4'd0;
      hold_q  <= 20'd0;
      frame_q <= 16'h0000;
      ser_q   <= 1'b0;
      sclk_q  <= 1'b0;
      rclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      ser_q   <= ser_d;
      sclk_q  <= sclk_d;
      rclk_q  <= rclk_d;
      done_q  <= done_d;
    end
  end

  assign ser        = ser_q;
  assign sclk       = sclk_q;
  assign rclk       = rclk_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_595.sv
// Bench for seg_scan_595: a scoreboard of expected 16-bit frames is filled whenever new
// inputs are driven; a monitor rebuilds each frame from ser on sclk rising edges and pops
// and compares one entry on every rclk rising edge. A second instance with SCLK_HALF=3
// checks sclk phase lengths and rclk width.

module tb_seg_scan_595;

  logic        clk;
  logic        rst;
  logic [39:0] seg_data;
  logic [7:0]  seg_data_en;
  logic [7:0]  seg_dot_en;
  logic        ser, sclk, rclk, frame_done;
  logic        ser3, sclk3, rclk3, fd3;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] SegTab [32] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h70, 8'h46, 8'h40, 8'h63, 8'h52, 8'h79,
    8'h00, 8'h50, 8'h48, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  seg_scan_595 #(
    .SCLK_HALF      (1),
    .DIGIT_HOLD     (4),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .seg_data    (seg_data),
    .seg_data_en (seg_data_en),
    .seg_dot_en  (seg_dot_en),
    .ser         (ser),
    .sclk        (sclk),
    .rclk        (rclk),
    .frame_done  (frame_done)
  );

  seg_scan_595 #(
    .SCLK_HALF      (3),
    .DIGIT_HOLD     (2),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .seg_data    (seg_data),
    .seg_data_en (seg_data_en),
    .seg_dot_en  (seg_dot_en),
    .ser         (ser3),
    .sclk        (sclk3),
    .rclk        (rclk3),
    .frame_done  (fd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ser may only move while sclk is low
  a_ser_quiet: assert property (@(posedge clk) disable iff (rst) $changed(ser) |-> !sclk);
  a_ser_quiet3: assert property (@(posedge clk) disable iff (rst) $changed(ser3) |-> !sclk3);

  // rst as seen by the DUT at the last rising edge, plus cycles since reset released
  logic rst_q;
  int   cyc;
  always @(posedge clk) begin
    rst_q <= rst;
    cyc   <= rst ? 0 : cyc + 1;
  end

  // ---------------- scoreboard model ----------------
  logic [15:0] exp_q[$];

  function automatic logic [15:0] model(input int d);
    logic [4:0] code;
    logic [7:0] seg, sel;
    code = seg_data[5*d +: 5];
    if (seg_data_en[d]) begin
      seg = SegTab[code] | (seg_dot_en[d] ? 8'h80 : 8'h00);
      sel = 8'h01 << d;
    end else begin
      seg = 8'h00;
      sel = 8'h00;
    end
    return {~seg, ~sel};
  endfunction

  task automatic push_all();
    for (int d = 0; d < 8; d++) exp_q.push_back(model(d));
  endtask

  task automatic set_inputs(input logic [39:0] data, input logic [7:0] en,
                            input logic [7:0] dot);
    seg_data    = data;
    seg_data_en = en;
    seg_dot_en  = dot;
  endtask

  // ---------------- monitor, SCLK_HALF=1 instance ----------------
  logic [15:0] shreg;
  int          bitcnt, n_frames, n_rise, last_rise;
  logic        sclk_p, rclk_p, fd_p, fd_pending;
  logic [15:0] e;

  initial begin
    n_frames = 0; bitcnt = 0; n_rise = 0; last_rise = 0;
    sclk_p = 0; rclk_p = 0; fd_p = 0; fd_pending = 0; shreg = 0;
  end

  always @(negedge clk) begin
    if (rst_q) begin
      bitcnt     = 0;
      n_rise     = 0;
      fd_pending = 0;
    end else begin
      if (fd_pending) begin
        check_eq("fd_width", 32'(frame_done), 0);
        fd_pending = 0;
      end
      if (sclk && !sclk_p) begin
        shreg  = {shreg[14:0], ser};
        bitcnt = bitcnt + 1;
      end
      if (rclk && !rclk_p) begin
        check_eq("frame_bits", bitcnt, 16);
        bitcnt = 0;
        if (n_rise == 0) check_eq("first_latch_cyc", cyc, 34);
        else check_eq("latch_period", cyc - last_rise, 38);
        last_rise = cyc;
        n_rise    = n_rise + 1;
        if (exp_q.size() == 0) begin
          check_eq("sb_pending", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("frame", 32'(shreg), 32'(e));
        end
        n_frames = n_frames + 1;
      end
      if (!rclk && rclk_p) check_eq("rclk_width", cyc - last_rise, 1);
      if (frame_done && !fd_p) begin
        check_eq("fd_digit", n_rise % 8, 0);
        check_eq("fd_cyc", cyc - last_rise, 1);
        fd_pending = 1;
      end
    end
    sclk_p = sclk;
    rclk_p = rclk;
    fd_p   = frame_done;
  end

  // ---------------- monitor, SCLK_HALF=3 instance ----------------
  int   b3, run3, rhi3;
  logic sclk3_p, rclk3_p;
  initial begin
    b3 = 0; run3 = 0; rhi3 = 0; sclk3_p = 0; rclk3_p = 0;
  end

  always @(negedge clk) begin
    if (rst_q) begin
      b3   = 0;
      run3 = 0;
      rhi3 = 0;
    end else begin
      if (sclk3 != sclk3_p) begin
        if (sclk3_p) check_eq("sclk3_high_len", run3, 3);
        else if (b3 > 0) check_eq("sclk3_low_len", run3, 3);
        if (sclk3) b3 = b3 + 1;
        run3 = 1;
      end else begin
        run3 = run3 + 1;
      end
      if (rclk3 && !rclk3_p) begin
        check_eq("frame_bits3", b3, 16);
        b3 = 0;
      end
      if (rclk3) rhi3 = rhi3 + 1;
      if (!rclk3 && rclk3_p) begin
        check_eq("rclk3_width", rhi3, 3);
        rhi3 = 0;
      end
    end
    sclk3_p = sclk3;
    rclk3_p = rclk3;
  end

  // ---------------- stimulus ----------------
  int target = 0;

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    target = target + n;
    while (n_frames < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("frames_seen", n_frames, target);
  endtask

  task automatic wait_bits(input int n, input int budget);
    int k = 0;
    while (bitcnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("shift_reached", 32'(bitcnt >= n), 1);
  endtask

  initial begin
    rst = 1'b1;
    set_inputs({35'd0, 5'd3}, 8'h01, 8'h00);
    repeat (3) @(negedge clk);
    check_eq("rst_out", 32'({ser, sclk, rclk, frame_done}), 0);
    check_eq("rst_out3", 32'({ser3, sclk3, rclk3, fd3}), 0);
    push_all();
    rst = 1'b0;
    wait_frames(8, 400);

    // every segment lit, walking select
    set_inputs({8{5'd8}}, 8'hFF, 8'hFF);
    push_all();
    wait_frames(8, 400);

    // nothing enabled: codes and dots must not leak through
    set_inputs({5'd18, 5'd17, 5'd15, 5'd9, 5'd8, 5'd3, 5'd1, 5'd0}, 8'h00, 8'hFF);
    push_all();
    wait_frames(8, 400);

    // undefined codes decode blank
    set_inputs({5'd31, 5'd30, 5'd29, 5'd23, 5'd22, 5'd21, 5'd20, 5'd19}, 8'hFF, 8'h00);
    push_all();
    wait_frames(8, 400);

    // symbol codes with mixed dots
    set_inputs({5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10}, 8'hFF, 8'hA5);
    push_all();
    wait_frames(8, 400);

    // digits with sparse enable and dots on some disabled digits
    set_inputs({5'd9, 5'd18, 5'd6, 5'd5, 5'd4, 5'd2, 5'd1, 5'd0}, 8'h7E, 8'h0F);
    push_all();
    wait_frames(8, 400);

    // change digit 0 mid-shift: current frame keeps the old code
    set_inputs({{7{5'd7}}, 5'd5}, 8'hFF, 8'h00);
    push_all();
    wait_bits(5, 100);
    seg_data[4:0] = 5'd6;
    push_all();
    wait_frames(16, 800);

    // reset mid-shift: no latch for the aborted frame, restart at digit 0
    wait_bits(8, 100);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_out", 32'({ser, sclk, rclk, frame_done}), 0);
    check_eq("sb_drained", exp_q.size(), 0);
    push_all();
    rst = 1'b0;
    wait_frames(8, 400);

    check_eq("sb_final", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
